// File: rtl/csa_add_arbiter.sv
// Round-robin arbiter sharing one external 16-bit adder among NREQ requesters.
// Define CSA_ARB_FIXED_PRIO_EN for fixed priority (lowest index always wins).
module csa_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  base;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  next_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW:0]    idx;
    logic            found;
    logic            hs;

`ifdef CSA_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDW-1:0] rr_ptr;
    assign base = rr_ptr;
`endif

    // Search for the first valid requester starting at base, wrapping at NREQ.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, base} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IDW-1:0]]   = 1'b1;
                grant_id              = idx[IDW-1:0];
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign busy      = (state != IDLE);
    assign next_ptr  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

    // Capture winner, run the adder for one cycle, hold the result until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            id        <= '0;
`ifndef CSA_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        add_a   <= req_a[grant_id*WIDTH +: WIDTH];
                        add_b   <= req_b[grant_id*WIDTH +: WIDTH];
                        add_cin <= req_cin[grant_id];
                        id      <= grant_id;
`ifndef CSA_ARB_FIXED_PRIO_EN
                        rr_ptr  <= next_ptr;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_add_arbiter.sv
// Directed self-checking bench for csa_add_arbiter.
// Models the external adder and checks cycle-exact behaviour.
module tb_csa_add_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_cin;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    csa_add_arbiter #(.NREQ(4), .WIDTH(16), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    // External adder model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_req_ready c%0d got %b exp 0000", c, req_ready);
            end
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_valid c%0d got %b exp 0", c, rsp_valid);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy c%0d got %b exp 0", c, busy);
            end
        end
        rst_n     = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_single;
        req_a[16 +: 16] = 16'd14;
        req_b[16 +: 16] = 16'd1;
        req_cin[1]      = 1'b1;
        req_valid       = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_exec got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 16'd16 || rsp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp got v=%b id=%0d sum=%0d c=%b exp v=1 id=1 sum=16 c=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_carry;
        logic [15:0] ta [2];
        logic [15:0] tb [2];
        logic        tc [2];
        logic [15:0] es [2];
        logic        ec [2];
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
        ta[1] = 16'd999;  tb[1] = 16'd0;    tc[1] = 1'b1; es[1] = 16'd1000; ec[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            req_a[0 +: 16] = ta[t];
            req_b[0 +: 16] = tb[t];
            req_cin[0]     = tc[t];
            req_valid      = 4'b0001;
            #1;
            n_checks++;
            if (req_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL carry_grant t%0d got %b exp 0001", t, req_ready);
            end
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== es[t] || rsp_cout !== ec[t]) begin
                n_fail++;
                $display("FAIL carry_rsp t%0d got v=%b id=%0d sum=%h c=%b exp v=1 id=0 sum=%h c=%b",
                         t, rsp_valid, rsp_id, rsp_sum, rsp_cout, es[t], ec[t]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        logic [15:0] sums [4];
        logic [1:0]  exp_id;
        sums[0] = 16'd100;
        sums[1] = 16'd202;
        sums[2] = 16'd302;
        sums[3] = 16'd404;
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(100 * (i + 1));
            req_b[i*16 +: 16] = 16'(i);
            req_cin[i]        = i[0];
        end
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
`ifdef CSA_ARB_FIXED_PRIO_EN
            exp_id = 2'd0;
`else
            exp_id = 2'(k % 4);
`endif
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << exp_id) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_grant k%0d got %b busy=%b exp %b busy=0",
                         k, req_ready, busy, 4'b0001 << exp_id);
            end
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== sums[exp_id]) begin
                n_fail++;
                $display("FAIL rr_rsp k%0d got v=%b id=%0d sum=%0d exp v=1 id=%0d sum=%0d",
                         k, rsp_valid, rsp_id, rsp_sum, exp_id, sums[exp_id]);
            end
            @(negedge clk);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure;
        logic [3:0]  exp_next;
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
`ifdef CSA_ARB_FIXED_PRIO_EN
        exp_next = 4'b0001; exp_id = 2'd0; exp_sum = 16'd100;
`else
        exp_next = 4'b1000; exp_id = 2'd3; exp_sum = 16'd404;
`endif
        req_a[32 +: 16] = 16'h1234;
        req_b[32 +: 16] = 16'h1111;
        req_cin[2]      = 1'b0;
        req_valid       = 4'b0100;
        rsp_ready       = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_grant got %b exp 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_exec_ready got %b exp 0000", req_ready);
        end
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 16'h2345 ||
                rsp_cout !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold j%0d got v=%b id=%0d sum=%h c=%b rdy=%b busy=%b exp 1 2 2345 0 0000 1",
                         j, rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready, busy);
            end
            if (j == 4)
                rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== exp_next) begin
            n_fail++;
            $display("FAIL bp_release got busy=%b v=%b rdy=%b exp 0 0 %b",
                     busy, rsp_valid, req_ready, exp_next);
        end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL bp_next_rsp got v=%b id=%0d sum=%0d exp 1 %0d %0d",
                     rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_exec_busy got %b exp 1", busy);
        end
        rst_n     = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_in_reset got v=%b busy=%b rdy=%b exp 0 0 0000",
                     rsp_valid, busy, req_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_after_reset_grant got %b exp 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_stale_rsp got %b exp 0", rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'd100) begin
            n_fail++;
            $display("FAIL mid_rsp got v=%b id=%0d sum=%0d exp 1 0 100",
                     rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
